regfile_dump_reader: RTL

Sequential reader for the 32x32 register file. On a start pulse it walks an address range through the regfile's two combinational read ports, two registers per cycle. Each {address, data} pair goes into a small buffer and streams out over a valid/ready interface. Used for debug dumps and end-of-test state checks. Also checks that register 0 reads as zero.

---
 rtl/regfile_dump_reader_pkg.sv | 15 +
 rtl/regfile_dump_reader_if.sv | 11 +
 rtl/regfile_dump_reader_fifo.sv | 43 ++++
 rtl/regfile_dump_reader.sv | 86 ++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// regfile_dump_pkg: shared constants, FSM states and FIFO entry type for the regfile dump reader
package regfile_dump_pkg;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PTRW = AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic last;
  } dump_entry_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready output stream of dump beats
interface regfile_dump_reader_if;
  import regfile_dump_pkg::*;
  logic out_valid;
  logic out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic out_last;
  modport master(output out_valid, out_addr, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader_fifo.sv
// dump_fifo: dual-push single-pop buffer of dump entries with registered count and free-slot output
module dump_fifo
  import regfile_dump_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic push1,
  input  logic push2,
  input  logic pop,
  input  dump_entry_t in1,
  input  dump_entry_t in2,
  output dump_entry_t head,
  output logic empty,
  output logic [CW-1:0] free
);
  localparam int PW = $clog2(FIFO_DEPTH);
  dump_entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr, wrPtr1;
  logic [CW-1:0] count;
  logic doPop;
  assign doPop = pop && count != '0;
  assign wrPtr1 = wrPtr + 1'b1;
  assign empty = count == '0;
  assign free = CW'(FIFO_DEPTH) - count;
  assign head = mem[rdPtr];
  // entry storage; a second push lands in the slot after the first
  always_ff @(posedge clk) begin
    if (push1) mem[wrPtr] <= in1;
    if (push2) mem[wrPtr1] <= in2;
  end
  // pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(push1) + PW'(push2);
      rdPtr <= rdPtr + PW'(doPop);
      count <= count + CW'(push1) + CW'(push2) - CW'(doPop);
    end
  end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range two reads per cycle and streams {addr,data,last} beats
module regfile_dump_reader
  import regfile_dump_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  regfile_dump_reader_if.master dumpOut,
  output logic busy,
  output logic done,
  output logic zero_err
);
  state_t state, stateNext;
  logic [PTRW-1:0] ptr, endReg, ptrPlus1, ptrNext;
  logic need2, canPush, zeroHit, fifoEmpty, startOk;
  logic [CW-1:0] free;
  dump_entry_t ent1, ent2, head;
  assign startOk = start && first_addr <= last_addr;
  assign busy = state != IDLE;
  assign done = state == FIN;
  // read addressing, push decision and entry formation; ptr is one bit wider so ptr+1 never wraps
  always_comb begin
    ptrPlus1 = ptr + 1'b1;
    need2 = ptrPlus1 <= endReg;
    canPush = state == READ && free >= (need2 ? CW'(2) : CW'(1));
    ptrNext = ptr + (need2 ? PTRW'(2) : PTRW'(1));
    ra1 = state == READ ? ptr[AW-1:0] : '0;
    ra2 = state == READ ? ptrPlus1[AW-1:0] : '0;
    ent1 = '{addr: ptr[AW-1:0], data: rd1, last: ptr == endReg};
    ent2 = '{addr: ptrPlus1[AW-1:0], data: rd2, last: ptrPlus1 == endReg};
    zeroHit = canPush && ptr == '0 && rd1 != '0;
  end
  // next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (start) stateNext = startOk ? READ : FIN;
      READ: if (canPush && ptrNext > endReg) stateNext = DRAIN;
      DRAIN: if (fifoEmpty) stateNext = FIN;
      FIN: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= stateNext;
  end
  // range pointer, end register and sticky register-0 check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      endReg <= '0;
      zero_err <= 1'b0;
    end else if (state == IDLE && startOk) begin
      ptr <= {1'b0, first_addr};
      endReg <= {1'b0, last_addr};
      zero_err <= 1'b0;
    end else if (canPush) begin
      ptr <= ptrNext;
      if (zeroHit) zero_err <= 1'b1;
    end
  end
  dump_fifo fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push1(canPush),
    .push2(canPush && need2),
    .pop(dumpOut.out_valid && dumpOut.out_ready),
    .in1(ent1),
    .in2(ent2),
    .head(head),
    .empty(fifoEmpty),
    .free(free)
  );
  assign dumpOut.out_valid = !fifoEmpty;
  assign dumpOut.out_addr = head.addr;
  assign dumpOut.out_data = head.data;
  assign dumpOut.out_last = head.last;
endmodule
